// File: rtl/mcu_reset_sequencer.sv
// Power-on reset and PLL bring-up sequencer: holds the PLL in reset through POR,
// qualifies lock, releases the MCU core, retries lock timeouts and latches a fault.
module mcu_reset_sequencer #(
    parameter int unsigned POR_CYCLES     = 40000000,
    parameter int unsigned PLL_RST_CYCLES = 500,
    parameter int unsigned LOCK_TIMEOUT   = 5000000,
    parameter int unsigned LOCK_STABLE    = 1000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 30
) (
    input  logic       CLK50M,
    input  logic       RSTN,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       core_rst_n_o,
    output logic       por_done_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    logic [1:0]       rst_sync_reg;
    logic             rst_n_int;
    logic [1:0]       lock_sync_reg;
    logic             lock_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] stable_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] stable_next;
    logic [3:0]       retry_cnt_reg;
    logic             pll_reset_reg;
    logic             core_rst_n_reg;
    logic             por_done_reg;
    logic             fail_reg;

    // Asserts with RSTN, releases on the second clock edge after RSTN rises.
    always_ff @(posedge CLK50M or negedge RSTN) begin
        if (!RSTN) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    always_ff @(posedge CLK50M or negedge rst_n_int) begin
        if (!rst_n_int) begin
            lock_sync_reg <= 2'b00;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], pll_lock_i};
        end
    end

    assign lock_s = lock_sync_reg[1];

    // Saturating increments so long dwell times can never wrap back into a match.
    assign cnt_next    = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign stable_next = (stable_reg == {CNT_W{1'b1}}) ? stable_reg : stable_reg + CNT_W'(1);

    // Outputs are updated together with the state so each one decodes the current state.
    always_ff @(posedge CLK50M or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg      <= ST_POR;
            cnt_reg        <= '0;
            stable_reg     <= '0;
            retry_cnt_reg  <= 4'd0;
            pll_reset_reg  <= 1'b1;
            core_rst_n_reg <= 1'b0;
            por_done_reg   <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_POR: begin
                    if (cnt_reg == POR_LAST) begin
                        state_reg     <= ST_WAIT_LOCK;
                        cnt_reg       <= '0;
                        stable_reg    <= '0;
                        por_done_reg  <= 1'b1;
                        pll_reset_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_PLL_RST: begin
                    if (cnt_reg == PLL_RST_LAST) begin
                        state_reg     <= ST_WAIT_LOCK;
                        cnt_reg       <= '0;
                        stable_reg    <= '0;
                        pll_reset_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_WAIT_LOCK: begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= lock_s ? stable_next : '0;
                    // Success is tested first so it wins over a coincident timeout.
                    if (lock_s && (stable_reg == STABLE_LAST)) begin
                        state_reg      <= ST_RUN;
                        retry_cnt_reg  <= 4'd0;
                        core_rst_n_reg <= 1'b1;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg       <= '0;
                        pll_reset_reg <= 1'b1;
                        if (retry_cnt_reg == RETRY_MAX) begin
                            state_reg <= ST_FAIL;
                            fail_reg  <= 1'b1;
                        end else begin
                            state_reg     <= ST_PLL_RST;
                            retry_cnt_reg <= retry_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_reg      <= ST_PLL_RST;
                        cnt_reg        <= '0;
                        pll_reset_reg  <= 1'b1;
                        core_rst_n_reg <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    pll_reset_reg  <= 1'b1;
                    core_rst_n_reg <= 1'b0;
                    fail_reg       <= 1'b1;
                end
                default: begin
                    state_reg      <= ST_POR;
                    cnt_reg        <= '0;
                    stable_reg     <= '0;
                    pll_reset_reg  <= 1'b1;
                    core_rst_n_reg <= 1'b0;
                    fail_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset_o  = pll_reset_reg;
    assign core_rst_n_o = core_rst_n_reg;
    assign por_done_o   = por_done_reg;
    assign fail_o       = fail_reg;
    assign retry_cnt_o  = retry_cnt_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// Bench for mcu_reset_sequencer: scenario tasks plus randomized lock patterns checked
// against a window/run-length model of lock qualification.
module tb_mcu_reset_sequencer;

    localparam int POR  = 100;
    localparam int PRST = 10;
    localparam int TMO  = 200;
    localparam int STB  = 16;
    localparam int MAXR = 2;

    logic       CLK50M = 1'b0;
    logic       RSTN = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       pll_reset_o;
    logic       core_rst_n_o;
    logic       por_done_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // pat[k] is the synchronized lock level seen by the k-th cycle of a lock attempt.
    bit         pat       [0:260];
    logic [2:0] obs_st    [0:260];
    logic       obs_core  [0:260];
    logic [3:0] obs_retry [0:260];

    mcu_reset_sequencer #(
        .POR_CYCLES(POR), .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT(TMO),
        .LOCK_STABLE(STB), .MAX_RETRY(MAXR), .CNT_W(30)
    ) dut (
        .CLK50M(CLK50M), .RSTN(RSTN), .pll_lock_i(pll_lock_i),
        .pll_reset_o(pll_reset_o), .core_rst_n_o(core_rst_n_o), .por_done_o(por_done_o),
        .fail_o(fail_o), .retry_cnt_o(retry_cnt_o), .state_o(state_o)
    );

    always #10 CLK50M = ~CLK50M;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK50M);
        #1;
        cyc++;
    endtask

    // Leaves the bench just after the internal reset release edge (T0).
    task automatic reset_dut(input bit lk);
        RSTN = 1'b0;
        pll_lock_i = lk;
        repeat (3) step();
        RSTN = 1'b1;
        repeat (2) step();
    endtask

    // Entered just after edge W-3 (W = WAIT_LOCK entry); leaves just after edge W+n.
    task automatic run_attempt(input int n);
        for (int i = 1; i <= n + 3; i++) begin
            step();
            pll_lock_i = pat[i];
            if (i >= 4) begin
                obs_st[i-3]    = state_o;
                obs_core[i-3]  = core_rst_n_o;
                obs_retry[i-3] = retry_cnt_o;
            end
        end
    endtask

    // Lock qualifies at the first attempt cycle closing a run of STB high samples.
    function automatic int predict_success(input int n);
        for (int k = STB; k <= n; k++) begin
            bit ok = 1'b1;
            for (int j = k - STB + 1; j <= k; j++) if (!pat[j]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic fill_pat(input bit v);
        for (int k = 0; k <= 260; k++) pat[k] = v;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        pll_lock_i = 1'b1;
        repeat (3) step();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (pll_reset_o !== 1'b1) begin errors++; $display("FAIL reset_pll: got %b expected 1", pll_reset_o); end
        checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL reset_core: got %b expected 0", core_rst_n_o); end
        checks++; if (por_done_o !== 1'b0 || fail_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got por_done=%b fail=%b expected 0 0", por_done_o, fail_o); end
        checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt_o); end
        RSTN = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_bringup();
        repeat (POR - 1) step();
        checks++; if (state_o !== 3'd0 || pll_reset_o !== 1'b1) begin errors++; $display("FAIL bringup_por_end: got state=%0d pll=%b expected 0 1", state_o, pll_reset_o); end
        step();
        checks++; if (state_o !== 3'd2 || pll_reset_o !== 1'b0) begin errors++; $display("FAIL bringup_wait: got state=%0d pll=%b expected 2 0", state_o, pll_reset_o); end
        checks++; if (por_done_o !== 1'b1) begin errors++; $display("FAIL bringup_por_done: got %b expected 1", por_done_o); end
        repeat (STB - 1) step();
        checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL bringup_early_core: got %b expected 0", core_rst_n_o); end
        step();
        checks++; if (core_rst_n_o !== 1'b1 || state_o !== 3'd3) begin errors++; $display("FAIL bringup_run: got core=%b state=%0d expected 1 3", core_rst_n_o, state_o); end
        checks++; if (retry_cnt_o !== 4'd0) begin errors++; $display("FAIL bringup_retry: got %0d expected 0", retry_cnt_o); end
    endtask

    task automatic test_lock_loss();
        int hi;
        pll_lock_i = 1'b0;
        repeat (3) step();
        checks++; if (core_rst_n_o !== 1'b0 || state_o !== 3'd1) begin errors++; $display("FAIL loss_core: got core=%b state=%0d expected 0 1", core_rst_n_o, state_o); end
        hi = int'(pll_reset_o);
        for (int m = 4; m <= 3 + PRST - 1; m++) begin
            step();
            if (m == 5) pll_lock_i = 1'b1;
            hi += int'(pll_reset_o);
        end
        checks++; if (hi != PRST) begin errors++; $display("FAIL loss_pll_pulse: got %0d high cycles expected %0d", hi, PRST); end
        step();
        checks++; if (pll_reset_o !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL loss_relock_wait: got pll=%b state=%0d expected 0 2", pll_reset_o, state_o); end
        repeat (STB - 1) step();
        checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL loss_early_core: got %b expected 0", core_rst_n_o); end
        step();
        checks++; if (core_rst_n_o !== 1'b1 || state_o !== 3'd3) begin errors++; $display("FAIL loss_rerun: got core=%b state=%0d expected 1 3", core_rst_n_o, state_o); end
        checks++; if (por_done_o !== 1'b1 || retry_cnt_o !== 4'd0) begin errors++; $display("FAIL loss_flags: got por_done=%b retry=%0d expected 1 0", por_done_o, retry_cnt_o); end
    endtask

    task automatic test_glitch();
        int ks;
        reset_dut(1'b0);
        repeat (POR - 3) step();
        fill_pat(1'b1);
        pat[11] = 1'b0;
        pat[12] = 1'b0;
        run_attempt(40);
        ks = predict_success(40);
        checks++; if (obs_st[ks-1] !== 3'd2 || obs_core[ks-1] !== 1'b0) begin errors++; $display("FAIL glitch_before: got state=%0d core=%b expected 2 0", obs_st[ks-1], obs_core[ks-1]); end
        checks++; if (obs_st[ks] !== 3'd3 || obs_core[ks] !== 1'b1) begin errors++; $display("FAIL glitch_release: got state=%0d core=%b expected 3 1 at cycle %0d", obs_st[ks], obs_core[ks], ks); end
    endtask

    task automatic test_no_lock();
        int per = TMO + PRST;
        int fail_at = (MAXR + 1) * TMO + MAXR * PRST;
        int bad = 0;
        int first_bad = -1;
        logic [2:0] es;
        logic [3:0] er;
        reset_dut(1'b0);
        repeat (POR) step();
        for (int t = 1; t <= fail_at; t++) begin
            step();
            if (t >= fail_at) es = 3'd4;
            else if ((t % per) >= TMO) es = 3'd1;
            else es = 3'd2;
            er = (t < TMO) ? 4'd0 : 4'(((t - TMO) / per + 1 > MAXR) ? MAXR : (t - TMO) / per + 1);
            if (state_o !== es || pll_reset_o !== (es != 3'd2) || retry_cnt_o !== er) begin
                bad++;
                if (first_bad < 0) first_bad = t;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nolock_windows: got %0d bad cycles (first at %0d) expected 0", bad, first_bad); end
        checks++; if (state_o !== 3'd4 || fail_o !== 1'b1) begin errors++; $display("FAIL nolock_fail: got state=%0d fail=%b expected 4 1", state_o, fail_o); end
        checks++; if (retry_cnt_o !== 4'(MAXR) || pll_reset_o !== 1'b1 || core_rst_n_o !== 1'b0) begin errors++; $display("FAIL nolock_outs: got retry=%0d pll=%b core=%b expected %0d 1 0", retry_cnt_o, pll_reset_o, core_rst_n_o, MAXR); end
        bad = 0;
        for (int t = 0; t < 10000; t++) begin
            step();
            if (t == 5000) pll_lock_i = 1'b1;
            if (state_o !== 3'd4 || fail_o !== 1'b1 || retry_cnt_o !== 4'(MAXR) || pll_reset_o !== 1'b1 || core_rst_n_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nolock_terminal: got %0d changed cycles expected 0", bad); end
    endtask

    task automatic test_rstn_mid();
        reset_dut(1'b0);
        repeat (POR + TMO + PRST + 50) step();
        checks++; if (retry_cnt_o !== 4'd1 || state_o !== 3'd2) begin errors++; $display("FAIL rstn_pre: got retry=%0d state=%0d expected 1 2", retry_cnt_o, state_o); end
        #5 RSTN = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0 || pll_reset_o !== 1'b1 || core_rst_n_o !== 1'b0) begin errors++; $display("FAIL rstn_async: got state=%0d pll=%b core=%b expected 0 1 0", state_o, pll_reset_o, core_rst_n_o); end
        checks++; if (por_done_o !== 1'b0 || fail_o !== 1'b0 || retry_cnt_o !== 4'd0) begin errors++; $display("FAIL rstn_async_flags: got por_done=%b fail=%b retry=%0d expected 0 0 0", por_done_o, fail_o, retry_cnt_o); end
        repeat (2) step();
        RSTN = 1'b1;
        repeat (2) step();
        repeat (POR - 1) step();
        checks++; if (state_o !== 3'd0 || por_done_o !== 1'b0) begin errors++; $display("FAIL rstn_por_repeat: got state=%0d por_done=%b expected 0 0", state_o, por_done_o); end
        step();
        checks++; if (state_o !== 3'd2 || por_done_o !== 1'b1) begin errors++; $display("FAIL rstn_por_end: got state=%0d por_done=%b expected 2 1", state_o, por_done_o); end
    endtask

    task automatic test_coincide();
        int ks;
        reset_dut(1'b0);
        repeat (POR - 3) step();
        fill_pat(1'b0);
        run_attempt(TMO);
        repeat (PRST - 3) step();
        run_attempt(TMO);
        checks++; if (retry_cnt_o !== 4'(MAXR) || state_o !== 3'd1) begin errors++; $display("FAIL coincide_pre: got retry=%0d state=%0d expected %0d 1", retry_cnt_o, state_o, MAXR); end
        repeat (PRST - 3) step();
        for (int k = TMO - STB + 1; k <= 260; k++) pat[k] = 1'b1;
        run_attempt(TMO);
        ks = predict_success(TMO);
        checks++; if (obs_st[ks-1] !== 3'd2) begin errors++; $display("FAIL coincide_wait: got state=%0d expected 2", obs_st[ks-1]); end
        checks++; if (obs_st[ks] !== 3'd3 || obs_core[ks] !== 1'b1) begin errors++; $display("FAIL coincide_run: got state=%0d core=%b expected 3 1", obs_st[ks], obs_core[ks]); end
        checks++; if (fail_o !== 1'b0 || obs_retry[ks] !== 4'd0) begin errors++; $display("FAIL coincide_flags: got fail=%b retry=%0d expected 0 0", fail_o, obs_retry[ks]); end
    endtask

    task automatic test_random_lock();
        for (int trial = 0; trial < 8; trial++) begin
            int s = $urandom_range(1, 220);
            int g;
            int ks;
            int lim;
            int bad = 0;
            case ($urandom_range(0, 2))
                0: g = 0;
                1: g = 24;
                default: g = 9;
            endcase
            for (int k = 0; k <= 260; k++)
                pat[k] = (k >= s) && !(g > 0 && $urandom_range(0, g - 1) == 0);
            reset_dut(1'b0);
            repeat (POR - 3) step();
            run_attempt(TMO);
            ks = predict_success(TMO);
            lim = (ks > 0) ? ks : TMO;
            for (int k = 1; k < lim; k++) if (obs_st[k] !== 3'd2 || obs_core[k] !== 1'b0) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL random_wait trial %0d: got %0d early exits expected 0 (success at %0d)", trial, bad, ks); end
            if (ks > 0) begin
                checks++; if (obs_st[ks] !== 3'd3 || obs_core[ks] !== 1'b1) begin errors++; $display("FAIL random_run trial %0d: got state=%0d core=%b expected 3 1 at cycle %0d", trial, obs_st[ks], obs_core[ks], ks); end
            end else begin
                checks++; if (obs_st[TMO] !== 3'd1 || obs_retry[TMO] !== 4'd1) begin errors++; $display("FAIL random_timeout trial %0d: got state=%0d retry=%0d expected 1 1", trial, obs_st[TMO], obs_retry[TMO]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss();
        test_glitch();
        test_no_lock();
        test_rstn_mid();
        test_coincide();
        test_random_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
